// File: rtl/motor_pwm_drive.sv
// motor_pwm_drive: dead-time H-bridge PWM driver; soft-start ramp built only with MOTOR_RAMP_EN defined
module motor_pwm_drive #(
    parameter int                  PWM_BITS    = 8,
    parameter logic [PWM_BITS-1:0] DUTY_MAX    = 8'd200,
    parameter int                  DEAD_CYCLES = 16,
    parameter logic [PWM_BITS-1:0] RAMP_STEP   = 8'd8,
    parameter int                  RAMP_DIV    = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] motorIn,
    output logic [1:0] left_in,
    output logic [1:0] right_in,
    output logic       settled
);
    typedef enum logic [1:0] {IDLE, DEAD, RUN} state_t;
    localparam int DW = DEAD_CYCLES > 1 ? $clog2(DEAD_CYCLES) : 1;
    localparam int RW = RAMP_DIV > 1 ? $clog2(RAMP_DIV) : 1;

    logic [3:0]          cmd_q;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic                settled_q, settled_d;
    state_t              state_q[2], state_d[2];
    logic [1:0]          act_q[2], act_d[2], tgt_q[2], tgt_d[2], out_q[2], out_d[2];
    logic [DW-1:0]       dead_q[2], dead_d[2];
    logic [PWM_BITS-1:0] duty_q[2], duty_d[2], duty_cmp_q[2], duty_cmp_d[2];
`ifdef MOTOR_RAMP_EN
    logic [RW-1:0]       ramp_q[2], ramp_d[2];
`else
    logic                unused_ramp;
    assign unused_ramp = ^{RAMP_STEP, RAMP_DIV[0]};
`endif

    always_comb begin
        logic [1:0]        code;
        logic [PWM_BITS:0] sum;
        logic              lvl, dir;
        pwm_cnt_d = pwm_cnt_q + 1'b1;
        settled_d = 1'b1;
        for (int c = 0; c < 2; c++) begin
            code = cmd_q[2*c +: 2];
            sum = {1'b0, duty_q[c]} + {1'b0, RAMP_STEP};
            state_d[c] = state_q[c];
            act_d[c] = act_q[c];
            tgt_d[c] = tgt_q[c];
            dead_d[c] = dead_q[c];
            duty_d[c] = duty_q[c];
`ifdef MOTOR_RAMP_EN
            ramp_d[c] = ramp_q[c];
`endif
            if (!enable) begin
                state_d[c] = IDLE;
                act_d[c] = 2'b00;
                tgt_d[c] = 2'b00;
                dead_d[c] = '0;
                duty_d[c] = '0;
`ifdef MOTOR_RAMP_EN
                ramp_d[c] = '0;
`endif
            end else if (state_q[c] == DEAD) begin
                if (code != tgt_q[c]) begin
                    tgt_d[c] = code;
                    dead_d[c] = DW'(DEAD_CYCLES - 1);
                end else if (dead_q[c] == '0) begin
                    act_d[c] = code;
                    state_d[c] = code == 2'b00 ? IDLE : RUN;
`ifdef MOTOR_RAMP_EN
                    duty_d[c] = '0;
                    ramp_d[c] = '0;
`else
                    duty_d[c] = (code == 2'b10 || code == 2'b01) ? DUTY_MAX : '0;
`endif
                end else begin
                    dead_d[c] = dead_q[c] - 1'b1;
                end
            end else if (code != act_q[c]) begin
                state_d[c] = DEAD;
                tgt_d[c] = code;
                dead_d[c] = DW'(DEAD_CYCLES - 1);
`ifdef MOTOR_RAMP_EN
            end else if (state_q[c] == RUN && (act_q[c] == 2'b10 || act_q[c] == 2'b01)) begin
                ramp_d[c] = ramp_q[c] == RW'(RAMP_DIV - 1) ? '0 : ramp_q[c] + 1'b1;
                if (ramp_q[c] == RW'(RAMP_DIV - 1))
                    duty_d[c] = sum > {1'b0, DUTY_MAX} ? DUTY_MAX : sum[PWM_BITS-1:0];
`endif
            end
            dir = act_d[c] == 2'b10 || act_d[c] == 2'b01;
            duty_cmp_d[c] = state_d[c] != RUN ? '0 : pwm_cnt_d == '0 ? duty_d[c] : duty_cmp_q[c];
            lvl = pwm_cnt_d < duty_cmp_d[c];
            out_d[c] = state_d[c] != RUN ? 2'b00 : act_d[c] == 2'b11 ? 2'b11 : act_d[c] & {2{lvl}};
            if (state_d[c] == DEAD || (state_d[c] == RUN && dir && duty_d[c] != DUTY_MAX))
                settled_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_q <= '0;
            pwm_cnt_q <= '0;
            settled_q <= 1'b1;
            for (int c = 0; c < 2; c++) begin
                state_q[c] <= IDLE;
                act_q[c] <= '0;
                tgt_q[c] <= '0;
                out_q[c] <= '0;
                dead_q[c] <= '0;
                duty_q[c] <= '0;
                duty_cmp_q[c] <= '0;
`ifdef MOTOR_RAMP_EN
                ramp_q[c] <= '0;
`endif
            end
        end else begin
            cmd_q <= motorIn;
            pwm_cnt_q <= pwm_cnt_d;
            settled_q <= settled_d;
            for (int c = 0; c < 2; c++) begin
                state_q[c] <= state_d[c];
                act_q[c] <= act_d[c];
                tgt_q[c] <= tgt_d[c];
                out_q[c] <= out_d[c];
                dead_q[c] <= dead_d[c];
                duty_q[c] <= duty_d[c];
                duty_cmp_q[c] <= duty_cmp_d[c];
`ifdef MOTOR_RAMP_EN
                ramp_q[c] <= ramp_d[c];
`endif
            end
        end
    end

    assign left_in = out_q[1];
    assign right_in = out_q[0];
    assign settled = settled_q;
endmodule

// File: tb/tb_motor_pwm_drive.sv
// tb_motor_pwm_drive: randomized bench against a timestamp-based model of dead-time, ramp and PWM
module tb_motor_pwm_drive;
    localparam int D = 4, DIV = 16, STEP = 5, MAXD = 12, PERIOD = 16;

    logic       clk = 1'b0, reset, enable;
    logic [3:0] motor_in;
    logic [1:0] left_in, right_in;
    logic       settled;
    int         n_tests = 0, n_fail = 0;
    int         e = 0, base = 0;
    logic [3:0] m_cmd;
    logic [1:0] m_act[2], m_tgt[2];
    bit         m_busy[2];
    int         m_ready[2], m_start[2];

    always #5 clk = ~clk;

    motor_pwm_drive #(
        .PWM_BITS(4), .DUTY_MAX(4'd12), .DEAD_CYCLES(D), .RAMP_STEP(4'd5), .RAMP_DIV(DIV)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .motorIn(motor_in),
        .left_in(left_in), .right_in(right_in), .settled(settled)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at edge %0d", tag, got, exp, e);
        end
    endtask

    function automatic int duty_at(input int c, input int t);
`ifdef MOTOR_RAMP_EN
        int d;
        d = STEP * ((t - m_start[c]) / DIV);
        return d > MAXD ? MAXD : d;
`else
        return MAXD;
`endif
    endfunction

    function automatic int exp_out(input int c);
        int p, w, cmp;
        if (m_busy[c] || m_act[c] == 2'b00) return 0;
        if (m_act[c] == 2'b11) return 3;
        p = (e - base) % PERIOD;
        w = e - p;
        cmp = w >= m_start[c] ? duty_at(c, w) : 0;
        return p < cmp ? int'(m_act[c]) : 0;
    endfunction

    function automatic int exp_settled();
        for (int c = 0; c < 2; c++) begin
            if (m_busy[c]) return 0;
            if ((m_act[c] == 2'b10 || m_act[c] == 2'b01) && duty_at(c, e) != MAXD) return 0;
        end
        return 1;
    endfunction

    task automatic tick();
        logic [1:0] code;
        @(posedge clk);
        e++;
        if (reset) begin
            base = e;
            m_cmd = 4'b0000;
            for (int c = 0; c < 2; c++) begin
                m_busy[c] = 1'b0;
                m_act[c] = 2'b00;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                code = m_cmd[2*c +: 2];
                if (!enable) begin
                    m_busy[c] = 1'b0;
                    m_act[c] = 2'b00;
                end else if (m_busy[c] ? code != m_tgt[c] : code != m_act[c]) begin
                    m_busy[c] = 1'b1;
                    m_tgt[c] = code;
                    m_ready[c] = e + D;
                end else if (m_busy[c] && e == m_ready[c]) begin
                    m_busy[c] = 1'b0;
                    m_act[c] = m_tgt[c];
                    m_start[c] = e;
                end
            end
            m_cmd = motor_in;
        end
        #1;
        check("left_in", int'(left_in), exp_out(1));
        check("right_in", int'(right_in), exp_out(0));
        check("settled", int'(settled), exp_settled());
    endtask

    task automatic hold(input logic [3:0] m, input int n);
        motor_in = m;
        repeat (n) tick();
    endtask

    initial begin
        int cnt_l, cnt_r;
        reset = 1'b1;
        enable = 1'b1;
        motor_in = 4'b0000;
        tick();
        tick();
        reset = 1'b0;
        hold(4'b0000, 20);
        hold(4'b1010, 100);
        cnt_l = 0;
        cnt_r = 0;
        repeat (PERIOD) begin
            tick();
            cnt_l += int'(left_in[1]);
            cnt_r += int'(right_in[1]);
        end
        check("left_high_per_period", cnt_l, MAXD);
        check("right_high_per_period", cnt_r, MAXD);
        hold(4'b0101, 80);
        hold(4'b1010, 60);
        hold(4'b0101, 2);
        hold(4'b1111, 20);
        hold(4'b1010, 30);
        enable = 1'b0;
        hold(4'b1010, 5);
        enable = 1'b1;
        hold(4'b1010, 40);
        hold(4'b0101, 3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        hold(4'b0000, 10);
        hold(4'b0110, 60);
        hold(4'b1101, 40);
        for (int i = 0; i < 150; i++) begin
            motor_in = 4'($urandom_range(0, 15));
            enable = $urandom_range(0, 9) != 0;
            if ($urandom_range(0, 29) == 0) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
            end
            repeat ($urandom_range(1, 40)) tick();
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
